// File: rtl/wb_master_mem_tester.sv
// Wishbone B4 memory self-test master: per-address single write then single read,
// readback compare, inverted alternate passes, bounded retries, ack timeout, counters.
module wb_master_mem_tester #(
  parameter int unsigned           ADDR_WIDTH  = 16,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           START_ADDR  = 0,
  parameter int unsigned           END_ADDR    = 15,
  parameter int unsigned           STEP        = 1,
  parameter logic [DATA_WIDTH-1:0] SEED        = '0,
  parameter int unsigned           MAX_RETRIES = 3,
  parameter int unsigned           TIMEOUT     = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    enable_i,
  output logic                    cyc_o,
  output logic                    stb_o,
  output logic                    we_o,
  output logic [ADDR_WIDTH-1:0]   adr_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic [DATA_WIDTH/8-1:0] sel_o,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic                    ack_i,
  input  logic                    err_i,
  output logic                    busy_o,
  output logic                    mismatch_o,
  output logic [15:0]             pass_cnt_o,
  output logic [15:0]             fail_cnt_o,
  output logic [15:0]             buserr_cnt_o
);

  localparam int unsigned SEL_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned AW1   = ADDR_WIDTH + 1;
  localparam int unsigned RT_W  = $clog2(MAX_RETRIES + 2);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_WR_WAIT, ST_RD, ST_RD_WAIT, ST_CHECK, ST_NEXT
  } state_e;

  // Reset asserts asynchronously and releases two edges later.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    parity_q, parity_d;
  logic [RT_W-1:0]         retry_q, retry_d;
  logic [TO_W-1:0]         to_q, to_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    busy_q, busy_d, mismatch_q, mismatch_d;
  logic [CNT_W-1:0]        pass_q, pass_d, fail_q, fail_d, buserr_q, buserr_d;

  logic [DATA_WIDTH-1:0]   pat_c;
  logic [AW1-1:0]          next_addr_c;
  logic                    to_hit_c;
  logic                    retry_ok_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign pat_c       = DATA_WIDTH'(addr_q) ^ SEED ^ {DATA_WIDTH{parity_q}};
  assign next_addr_c = AW1'(addr_q) + AW1'(STEP);
  assign to_hit_c    = (32'(to_q) + 32'd1) >= TIMEOUT;
  assign retry_ok_c  = 32'(retry_q) < MAX_RETRIES;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    parity_d   = parity_q;
    retry_d    = retry_q;
    to_d       = to_q;
    rdata_d    = rdata_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    mismatch_d = 1'b0;
    pass_d     = pass_q;
    fail_d     = fail_q;
    buserr_d   = buserr_q;

    unique case (state_q)
      ST_IDLE: if (enable_i) state_d = ST_WRITE;
      ST_WRITE: begin
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = 1'b1;
        adr_d   = addr_q;
        dat_d   = pat_c;
        sel_d   = '1;
        to_d    = '0;
        state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (ack_i) begin
          stb_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ST_RD;
        end else if (err_i || to_hit_c) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          if (err_i && retry_ok_c) begin
            retry_d = retry_q + RT_W'(1);
            state_d = ST_WRITE;
          end else begin
            buserr_d = sat_inc(buserr_q);
            state_d  = ST_NEXT;
          end
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      ST_RD: begin
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = 1'b0;
        sel_d   = '1;
        to_d    = '0;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (ack_i) begin
          rdata_d    = dat_i;
          mismatch_d = (dat_i != pat_c);
          cyc_d      = 1'b0;
          stb_d      = 1'b0;
          state_d    = ST_CHECK;
        end else if (err_i || to_hit_c) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          if (err_i && retry_ok_c) begin
            retry_d = retry_q + RT_W'(1);
            state_d = ST_RD;
          end else begin
            buserr_d = sat_inc(buserr_q);
            state_d  = ST_NEXT;
          end
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      ST_CHECK: begin
        if (rdata_q != pat_c) fail_d = sat_inc(fail_q);
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        retry_d = '0;
        to_d    = '0;
        // Wide compare so an address overflow past END_ADDR still wraps.
        if (next_addr_c > AW1'(END_ADDR)) begin
          addr_d   = ADDR_WIDTH'(START_ADDR);
          parity_d = ~parity_q;
          pass_d   = sat_inc(pass_q);
        end else begin
          addr_d = next_addr_c[ADDR_WIDTH-1:0];
        end
        state_d = enable_i ? ST_WRITE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= ADDR_WIDTH'(START_ADDR);
      parity_q   <= 1'b0;
      retry_q    <= '0;
      to_q       <= '0;
      rdata_q    <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      mismatch_q <= 1'b0;
      pass_q     <= '0;
      fail_q     <= '0;
      buserr_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      parity_q   <= parity_d;
      retry_q    <= retry_d;
      to_q       <= to_d;
      rdata_q    <= rdata_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      mismatch_q <= mismatch_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      buserr_q   <= buserr_d;
    end
  end

  assign cyc_o        = cyc_q;
  assign stb_o        = stb_q;
  assign we_o         = we_q;
  assign adr_o        = adr_q;
  assign dat_o        = dat_q;
  assign sel_o        = sel_q;
  assign busy_o       = busy_q;
  assign mismatch_o   = mismatch_q;
  assign pass_cnt_o   = pass_q;
  assign fail_cnt_o   = fail_q;
  assign buserr_cnt_o = buserr_q;

endmodule

// File: tb/tb_wb_master_mem_tester.sv
// Directed bench: small sweeps against behavioural memory slaves with
// corrupt / err / no-ack knobs, plus a stepped sweep on a second instance.
`timescale 1ns/1ps
module tb_wb_master_mem_tester;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] SEED3 = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst_n, enable, enable3;
  logic cyc, stb, we, ack, err, busy, mismatch;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w, dat_r;
  logic [3:0] sel;
  logic [15:0] pass_cnt, fail_cnt, buserr_cnt;
  logic cyc3, stb3, we3, ack3, err3, busy3, mismatch3;
  logic [AW-1:0] adr3;
  logic [DW-1:0] dat_w3, dat_r3;
  logic [3:0] sel3;
  logic [15:0] pass_cnt3, fail_cnt3, buserr_cnt3;

  logic ack_en, corrupt;
  logic [AW-1:0] err_addr;
  int err_budget, err_used;
  logic [DW-1:0] mem [0:15];
  logic [DW-1:0] mem3 [0:7];
  int rd_cnt [0:15];
  logic [AW-1:0] wr_adr_q[$], wr_adr3_q[$];
  logic [DW-1:0] wr_dat_q[$], wr_dat3_q[$];
  int passed, total;

  always #5 clk = ~clk;

  wb_master_mem_tester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(0), .END_ADDR(3), .STEP(1),
    .SEED('0), .MAX_RETRIES(3), .TIMEOUT(4)
  ) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_w), .sel_o(sel),
    .dat_i(dat_r), .ack_i(ack), .err_i(err),
    .busy_o(busy), .mismatch_o(mismatch),
    .pass_cnt_o(pass_cnt), .fail_cnt_o(fail_cnt), .buserr_cnt_o(buserr_cnt)
  );

  wb_master_mem_tester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(0), .END_ADDR(7), .STEP(3),
    .SEED(SEED3), .MAX_RETRIES(3), .TIMEOUT(255)
  ) u_dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable3),
    .cyc_o(cyc3), .stb_o(stb3), .we_o(we3), .adr_o(adr3), .dat_o(dat_w3), .sel_o(sel3),
    .dat_i(dat_r3), .ack_i(ack3), .err_i(err3),
    .busy_o(busy3), .mismatch_o(mismatch3),
    .pass_cnt_o(pass_cnt3), .fail_cnt_o(fail_cnt3), .buserr_cnt_o(buserr_cnt3)
  );

  // Zero-wait memory slaves; err is raised only on writes to err_addr.
  assign err    = cyc & stb & we & (adr == err_addr) & (err_used < err_budget);
  assign ack    = cyc & stb & ack_en & ~err;
  assign dat_r  = mem[adr[3:0]] ^ {31'd0, corrupt & (adr == 16'd2)};
  assign ack3   = cyc3 & stb3;
  assign err3   = 1'b0;
  assign dat_r3 = mem3[adr3[2:0]];

  always @(posedge clk) begin
    if (cyc && stb && we && ack) begin
      mem[adr[3:0]] <= dat_w;
      wr_adr_q.push_back(adr);
      wr_dat_q.push_back(dat_w);
    end
    if (cyc && stb && !we && ack) rd_cnt[adr[3:0]] <= rd_cnt[adr[3:0]] + 1;
    if (err) err_used <= err_used + 1;
    if (cyc3 && stb3 && we3 && ack3) begin
      mem3[adr3[2:0]] <= dat_w3;
      wr_adr3_q.push_back(adr3);
      wr_dat3_q.push_back(dat_w3);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; enable3 = 1'b0;
    ack_en = 1'b1; corrupt = 1'b0; err_addr = '0; err_budget = 0;
    #12;
    total++; if ({cyc, stb, we} !== 3'b000) $display("FAIL rst_bus: got %b want 000", {cyc, stb, we}); else passed++;
    total++; if (adr !== 16'd0) $display("FAIL rst_adr: got %h want 0", adr); else passed++;
    total++; if (dat_w !== 32'd0) $display("FAIL rst_dat: got %h want 0", dat_w); else passed++;
    total++; if (sel !== 4'h0) $display("FAIL rst_sel: got %h want 0", sel); else passed++;
    total++; if ({busy, mismatch} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {busy, mismatch}); else passed++;
    total++; if ({pass_cnt, fail_cnt, buserr_cnt} !== 48'd0)
      $display("FAIL rst_cnt: got %h/%h/%h want 0/0/0", pass_cnt, fail_cnt, buserr_cnt); else passed++;
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_sweep();
    int base;
    logic [DW-1:0] exp_d;
    logic [AW-1:0] exp_a;
    base = wr_adr_q.size();
    total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
    enable = 1'b1;
    tick(1);
    total++; if ({busy, cyc} !== 2'b10) $display("FAIL write_state: got %b want 10", {busy, cyc}); else passed++;
    tick(1);
    total++; if ({cyc, stb, we} !== 3'b111 || adr !== 16'd0 || dat_w !== 32'd0 || sel !== 4'hF)
      $display("FAIL wr_phase: got %b adr %h dat %h sel %h want 111/0/0/f", {cyc, stb, we}, adr, dat_w, sel); else passed++;
    tick(1);
    total++; if ({cyc, stb, we} !== 3'b100) $display("FAIL stb_gap: got %b want 100", {cyc, stb, we}); else passed++;
    tick(1);
    total++; if ({cyc, stb, we} !== 3'b110) $display("FAIL rd_phase: got %b want 110", {cyc, stb, we}); else passed++;
    tick(1);
    total++; if ({cyc, stb, mismatch} !== 3'b000) $display("FAIL check_cycle: got %b want 000", {cyc, stb, mismatch}); else passed++;
    tick(44);
    total++; if (pass_cnt !== 16'd2 || fail_cnt !== 16'd0)
      $display("FAIL sweep_cnt: got pass %0d fail %0d want 2/0", pass_cnt, fail_cnt); else passed++;
    total++; if (wr_adr_q.size() - base !== 8) $display("FAIL sweep_nwr: got %0d want 8", wr_adr_q.size() - base); else passed++;
    for (int k = 0; k < 8; k++) begin
      exp_a = AW'(k % 4);
      exp_d = (k < 4) ? DW'(k % 4) : ~DW'(k % 4);
      total++;
      if (base + k >= wr_adr_q.size()) $display("FAIL sweep_wr%0d: got none want %h@%h", k, exp_d, exp_a);
      else if (wr_adr_q[base + k] !== exp_a || wr_dat_q[base + k] !== exp_d)
        $display("FAIL sweep_wr%0d: got %h@%h want %h@%h", k, wr_dat_q[base + k], wr_adr_q[base + k], exp_d, exp_a);
      else passed++;
    end
  endtask

  task automatic test_enable_drop();
    tick(3);
    enable = 1'b0;
    tick(1);
    total++; if (rd_cnt[0] !== 3) $display("FAIL drop_read: got %0d want 3", rd_cnt[0]); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL drop_busy_check: got %b want 1", busy); else passed++;
    tick(2);
    total++; if ({busy, cyc} !== 2'b00) $display("FAIL drop_idle: got %b want 00", {busy, cyc}); else passed++;
  endtask

  task automatic test_mismatch();
    int pulses, first;
    bit ok;
    pulses = 0; first = -1;
    corrupt = 1'b1; enable = 1'b1;
    tick(1);
    for (int i = 1; i <= 36; i++) begin
      tick(1);
      if (mismatch === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (i == 11) begin
        total++; if (fail_cnt !== 16'd1) $display("FAIL mm_fail1: got %0d want 1", fail_cnt); else passed++;
      end
    end
    total++; if (pulses !== 2) $display("FAIL mm_pulses: got %0d want 2", pulses); else passed++;
    total++; if (first !== 10) $display("FAIL mm_first: got %0d want 10", first); else passed++;
    total++; if (fail_cnt !== 16'd2) $display("FAIL mm_fail2: got %0d want 2", fail_cnt); else passed++;
    enable = 1'b0;
    wait_idle(20, ok);
    total++; if (!ok) $display("FAIL mm_idle: got busy %b want 0", busy); else passed++;
    total++; if (pass_cnt !== 16'd4) $display("FAIL mm_pass: got %0d want 4", pass_cnt); else passed++;
    corrupt = 1'b0;
  endtask

  task automatic test_retry();
    int base, snap;
    bit ok;
    base = wr_adr_q.size(); snap = rd_cnt[1];
    err_addr = 16'd1; err_budget = err_used + 2;
    enable = 1'b1;
    tick(1);
    tick(8);
    total++; if (cyc !== 1'b0) $display("FAIL retry_drop: got %b want 0", cyc); else passed++;
    tick(1);
    total++; if ({cyc, stb, we} !== 3'b111 || adr !== 16'd1)
      $display("FAIL retry_reassert: got %b adr %h want 111 adr 1", {cyc, stb, we}, adr); else passed++;
    enable = 1'b0;
    wait_idle(30, ok);
    total++; if (!ok) $display("FAIL retry_idle: got busy %b want 0", busy); else passed++;
    total++; if (buserr_cnt !== 16'd0) $display("FAIL retry_buserr: got %0d want 0", buserr_cnt); else passed++;
    total++; if (rd_cnt[1] !== snap + 1) $display("FAIL retry_read: got %0d want %0d", rd_cnt[1], snap + 1); else passed++;
    total++; if (wr_adr_q.size() - base !== 2 || wr_adr_q[wr_adr_q.size() - 1] !== 16'd1 || wr_dat_q[wr_dat_q.size() - 1] !== 32'd1)
      $display("FAIL retry_write: got n=%0d want 2 writes ending 1@1", wr_adr_q.size() - base); else passed++;
    total++; if (err_used !== err_budget) $display("FAIL retry_errs: got %0d want %0d", err_used, err_budget); else passed++;
  endtask

  task automatic test_buserr();
    int base, snap;
    bit ok, got;
    base = wr_adr_q.size(); snap = rd_cnt[2];
    err_addr = 16'd2; err_budget = err_used + 4;
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    wait_idle(40, ok);
    total++; if (!ok) $display("FAIL be_idle: got busy %b want 0", busy); else passed++;
    total++; if (buserr_cnt !== 16'd1) $display("FAIL be_cnt: got %0d want 1", buserr_cnt); else passed++;
    total++; if (rd_cnt[2] !== snap || wr_adr_q.size() !== base)
      $display("FAIL be_noaccess: got rd %0d wr %0d want rd %0d wr %0d", rd_cnt[2], wr_adr_q.size(), snap, base); else passed++;
    enable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(1);
      if (wr_adr_q.size() > base) got = 1'b1;
    end
    enable = 1'b0;
    total++; if (!got || wr_adr_q[base] !== 16'd3) $display("FAIL be_continue: got %b adr %h want adr 3", got, adr); else passed++;
    wait_idle(20, ok);
    total++; if (!ok) $display("FAIL be_idle2: got busy %b want 0", busy); else passed++;
  endtask

  task automatic test_timeout();
    bit ok;
    ack_en = 1'b0; enable = 1'b1;
    tick(1);
    tick(4);
    total++; if (cyc !== 1'b1) $display("FAIL to_wait: got %b want 1", cyc); else passed++;
    tick(1);
    total++; if (cyc !== 1'b0 || buserr_cnt !== 16'd2)
      $display("FAIL to_fire: got cyc %b buserr %0d want 0/2", cyc, buserr_cnt); else passed++;
    tick(1);
    enable = 1'b0;
    wait_idle(30, ok);
    total++; if (!ok || buserr_cnt !== 16'd3) $display("FAIL to_second: got idle %b buserr %0d want 1/3", ok, buserr_cnt); else passed++;
  endtask

  task automatic test_step();
    logic [AW-1:0] ea [4];
    logic [DW-1:0] ed;
    bit got, idle3;
    ea[0] = 16'd0; ea[1] = 16'd3; ea[2] = 16'd6; ea[3] = 16'd0;
    enable3 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick(1);
      if (wr_adr3_q.size() >= 4) got = 1'b1;
    end
    enable3 = 1'b0;
    total++; if (!got) $display("FAIL step_writes: got %0d want 4", wr_adr3_q.size()); else passed++;
    for (int k = 0; k < 4; k++) begin
      ed = (k < 3) ? (SEED3 ^ DW'(ea[k])) : ~SEED3;
      total++;
      if (k >= wr_adr3_q.size()) $display("FAIL step_wr%0d: got none want %h@%h", k, ed, ea[k]);
      else if (wr_adr3_q[k] !== ea[k] || wr_dat3_q[k] !== ed)
        $display("FAIL step_wr%0d: got %h@%h want %h@%h", k, wr_dat3_q[k], wr_adr3_q[k], ed, ea[k]);
      else passed++;
    end
    total++; if (pass_cnt3 !== 16'd1) $display("FAIL step_pass: got %0d want 1", pass_cnt3); else passed++;
    idle3 = 1'b0;
    for (int i = 0; i < 20 && !idle3; i++) begin
      tick(1);
      if (busy3 === 1'b0) idle3 = 1'b1;
    end
    total++; if (!idle3) $display("FAIL step_idle: got busy %b want 0", busy3); else passed++;
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    tick(2);
    total++; if (cyc !== 1'b1) $display("FAIL ar_pre: got %b want 1", cyc); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({cyc, stb, we, busy, mismatch} !== 5'b0) $display("FAIL ar_bus: got %b want 00000", {cyc, stb, we, busy, mismatch}); else passed++;
    total++; if (adr !== 16'd0 || dat_w !== 32'd0 || sel !== 4'h0)
      $display("FAIL ar_data: got %h/%h/%h want 0/0/0", adr, dat_w, sel); else passed++;
    total++; if ({pass_cnt, fail_cnt, buserr_cnt} !== 48'd0)
      $display("FAIL ar_cnt: got %h/%h/%h want 0/0/0", pass_cnt, fail_cnt, buserr_cnt); else passed++;
    enable = 1'b0;
    ack_en = 1'b1;
  endtask

  initial begin
    passed = 0; total = 0;
    test_reset();
    test_sweep();
    test_enable_drop();
    test_mismatch();
    test_retry();
    test_buserr();
    test_timeout();
    test_step();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100us");
    $fatal(1);
  end

endmodule
